// File: rtl/conv_stream_pkg.sv
// Shared types and helpers for the streaming convolver: FSM states, counter and
// address width helpers, and the output saturate/truncate formatter.
package conv_stream_pkg;

  typedef enum logic {
    LOAD    = 1'b0,
    COMPUTE = 1'b1
  } state_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to address 'depth' entries.
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Width of the pass counter, which runs 0..F_SIZE/LANES-1.
  function automatic int pass_w(input int f_size, input int lanes);
    return addr_w(f_size / lanes);
  endfunction

  // The caller sign-extends the ACC_W accumulator to 64 bits and keeps the low
  // out_w bits of the result; clamping only matters when out_w is narrower.
  function automatic logic signed [63:0] fmt_out(input logic signed [63:0] v,
                                                 input int acc_w,
                                                 input int out_w,
                                                 input bit sat);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (sat && out_w < acc_w) begin
      if (v > mx) return mx;
      if (v < mn) return mn;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_stream_par_lane_tree.sv
// LANES signed multipliers feeding a purely combinational adder tree; every
// product and partial sum is carried at ACC_W bits.
module conv_lane_tree #(
  parameter int DW_X  = 8,
  parameter int DW_F  = 8,
  parameter int LANES = 8,
  parameter int ACC_W = 21
) (
  input  logic signed [DW_X-1:0]  x_i [LANES],
  input  logic signed [DW_F-1:0]  f_i [LANES],
  output logic signed [ACC_W-1:0] sum_o
);

  localparam int LVLS = (LANES <= 1) ? 0 : $clog2(LANES);
  localparam int NP   = 1 << LVLS;

  logic signed [ACC_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0] node [NP];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    assign prod[gi] = ACC_W'(x_i[gi]) * ACC_W'(f_i[gi]);
  end

  // Leaves padded to a power of two with zeros, then pairwise reduction.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      node[i] = (i < LANES) ? prod[i] : '0;
    end
    for (int w = NP / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    sum_o = node[0];
  end

endmodule

// File: rtl/conv_stream_par.sv
// Streaming convolver: loads an X frame and F filter, then emits every valid
// output using LANES multipliers per cycle behind a backpressure-safe register.
module conv_stream_par
  import conv_stream_pkg::*;
#(
  parameter int DW_X   = 8,
  parameter int DW_F   = 8,
  parameter int X_SIZE = 128,
  parameter int F_SIZE = 32,
  parameter int LANES  = 8,
  parameter int ACC_W  = 21,
  parameter int OUT_W  = 21,
  parameter int SAT    = 0,
  parameter int KEEP_F = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  input  logic signed [DW_X-1:0]  s_data_in_x,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [DW_F-1:0]  s_data_in_f,
  output logic                    m_valid_y,
  input  logic                    m_ready_y,
  output logic signed [OUT_W-1:0] m_data_out_y
);

  localparam int P    = F_SIZE / LANES;
  localparam int NMAX = X_SIZE - F_SIZE;
  localparam int XCW  = cnt_w(X_SIZE);
  localparam int FCW  = cnt_w(F_SIZE);
  localparam int XAW  = addr_w(X_SIZE);
  localparam int FAW  = addr_w(F_SIZE);
  localparam int NW   = cnt_w(NMAX);
  localparam int PW   = pass_w(F_SIZE, LANES);

  state_e                  state_q, state_d;
  logic [XCW-1:0]          xcnt_q, xcnt_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic [NW-1:0]           n_q, n_d;
  logic [PW-1:0]           p_q, p_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    last_q, last_d;
  logic                    rdx_q, rdx_d;
  logic                    rdf_q, rdf_d;
  logic                    yv_q, yv_d;
  logic signed [OUT_W-1:0] y_q, y_d;

  logic signed [DW_X-1:0]  xmem [X_SIZE];
  logic signed [DW_F-1:0]  fmem [F_SIZE];
  logic signed [DW_X-1:0]  x_lane [LANES];
  logic signed [DW_F-1:0]  f_lane [LANES];
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    x_fire, f_fire, y_accept;

  assign x_fire    = s_valid_x & rdx_q;
  assign f_fire    = s_valid_f & rdf_q;
  assign y_accept  = yv_q & m_ready_y;
  assign acc_sum   = ((p_q == '0) ? '0 : acc_q) + lane_sum;

  assign s_ready_x    = rdx_q;
  assign s_ready_f    = rdf_q;
  assign m_valid_y    = yv_q;
  assign m_data_out_y = y_q;

  always_ff @(posedge clk) begin
    if (x_fire) xmem[xcnt_q[XAW-1:0]] <= s_data_in_x;
    if (f_fire) fmem[fcnt_q[FAW-1:0]] <= s_data_in_f;
  end

  // Lane l of pass p for output n reads x[n + p*LANES + l] and f[p*LANES + l].
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [XAW-1:0] xi;
    logic [FAW-1:0] fi;
    assign xi          = XAW'(n_q) + XAW'(p_q) * XAW'(LANES) + XAW'(gi);
    assign fi          = FAW'(p_q) * FAW'(LANES) + FAW'(gi);
    assign x_lane[gi]  = xmem[xi];
    assign f_lane[gi]  = fmem[fi];
  end

  conv_lane_tree #(
    .DW_X (DW_X),
    .DW_F (DW_F),
    .LANES(LANES),
    .ACC_W(ACC_W)
  ) u_tree (
    .x_i  (x_lane),
    .f_i  (f_lane),
    .sum_o(lane_sum)
  );

  always_comb begin
    state_d = state_q;
    xcnt_d  = xcnt_q;
    fcnt_d  = fcnt_q;
    n_d     = n_q;
    p_d     = p_q;
    acc_d   = acc_q;
    last_d  = last_q;
    rdx_d   = rdx_q;
    rdf_d   = rdf_q;
    yv_d    = y_accept ? 1'b0 : yv_q;
    y_d     = y_q;
    unique case (state_q)
      LOAD: begin
        if (x_fire) begin
          xcnt_d = xcnt_q + XCW'(1);
          if (xcnt_q == XCW'(X_SIZE - 1)) rdx_d = 1'b0;
        end
        if (f_fire) begin
          fcnt_d = fcnt_q + FCW'(1);
          if (fcnt_q == FCW'(F_SIZE - 1)) rdf_d = 1'b0;
        end
        if (xcnt_d == XCW'(X_SIZE) && fcnt_d == FCW'(F_SIZE)) begin
          state_d = COMPUTE;
          n_d     = '0;
          p_d     = '0;
          last_d  = 1'b0;
        end
      end
      COMPUTE: begin
        if (!last_q) begin
          if (p_q != PW'(P - 1)) begin
            acc_d = acc_sum;
            p_d   = p_q + PW'(1);
          end else if (!yv_q || m_ready_y) begin
            // Final pass only retires when the output register can take it.
            yv_d = 1'b1;
            y_d  = OUT_W'(fmt_out(64'(acc_sum), ACC_W, OUT_W, SAT != 0));
            p_d  = '0;
            if (n_q == NW'(NMAX)) last_d = 1'b1;
            else                  n_d    = n_q + NW'(1);
          end
        end else if (y_accept) begin
          state_d = LOAD;
          xcnt_d  = '0;
          rdx_d   = 1'b1;
          last_d  = 1'b0;
          n_d     = '0;
          if (KEEP_F == 0) begin
            fcnt_d = '0;
            rdf_d  = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      xcnt_q  <= '0;
      fcnt_q  <= '0;
      n_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      last_q  <= 1'b0;
      rdx_q   <= 1'b1;
      rdf_q   <= 1'b1;
      yv_q    <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      xcnt_q  <= xcnt_d;
      fcnt_q  <= fcnt_d;
      n_q     <= n_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      last_q  <= last_d;
      rdx_q   <= rdx_d;
      rdf_q   <= rdf_d;
      yv_q    <= yv_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_par.sv
// Bench for conv_stream_par: three configurations (LANES=2 wide output,
// LANES=4 saturating with filter retention, LANES=1 truncating to 8 bits).
module tb_conv_stream_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       vx  [3];
  logic       vf  [3];
  logic       mr  [3];
  logic       rx  [3];
  logic       rf  [3];
  logic       yv  [3];
  logic [7:0] dx  [3];
  logic [7:0] df  [3];
  logic [20:0] y0;
  logic [7:0]  y1;
  logic [7:0]  y2;

  int errors = 0;
  int checks = 0;
  int kf [3][4];
  bit f_have [3];

  conv_stream_par #(.DW_X(8), .DW_F(8), .X_SIZE(8), .F_SIZE(4), .LANES(2),
                    .ACC_W(21), .OUT_W(21), .SAT(0), .KEEP_F(0)) dut0 (
    .clk(clk), .reset(rst[0]), .s_valid_x(vx[0]), .s_ready_x(rx[0]),
    .s_data_in_x(dx[0]), .s_valid_f(vf[0]), .s_ready_f(rf[0]),
    .s_data_in_f(df[0]), .m_valid_y(yv[0]), .m_ready_y(mr[0]),
    .m_data_out_y(y0));

  conv_stream_par #(.DW_X(8), .DW_F(8), .X_SIZE(8), .F_SIZE(4), .LANES(4),
                    .ACC_W(21), .OUT_W(8), .SAT(1), .KEEP_F(1)) dut1 (
    .clk(clk), .reset(rst[1]), .s_valid_x(vx[1]), .s_ready_x(rx[1]),
    .s_data_in_x(dx[1]), .s_valid_f(vf[1]), .s_ready_f(rf[1]),
    .s_data_in_f(df[1]), .m_valid_y(yv[1]), .m_ready_y(mr[1]),
    .m_data_out_y(y1));

  conv_stream_par #(.DW_X(8), .DW_F(8), .X_SIZE(8), .F_SIZE(4), .LANES(1),
                    .ACC_W(21), .OUT_W(8), .SAT(0), .KEEP_F(0)) dut2 (
    .clk(clk), .reset(rst[2]), .s_valid_x(vx[2]), .s_ready_x(rx[2]),
    .s_data_in_x(dx[2]), .s_valid_f(vf[2]), .s_ready_f(rf[2]),
    .s_data_in_f(df[2]), .m_valid_y(yv[2]), .m_ready_y(mr[2]),
    .m_data_out_y(y2));

  function automatic int p_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : 4;
  endfunction
  function automatic int ow_of(input int d);
    return (d == 0) ? 21 : 8;
  endfunction
  function automatic int get_y(input int d);
    if (d == 0) return int'($signed(y0));
    if (d == 1) return int'($signed(y1));
    return int'($signed(y2));
  endfunction

  // Reference: plain dot product, then clamp or wrap to the output width.
  function automatic int fmt(input int d, input int s);
    int ow, hi, lo, m;
    ow = ow_of(d);
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (d == 1) return (s > hi) ? hi : (s < lo) ? lo : s;
    m = s & ((1 << ow) - 1);
    if (m > hi) m -= (1 << ow);
    return m;
  endfunction

  function automatic int ref_y(input int d, input int xs[$], input int n);
    int s = 0;
    for (int k = 0; k < 4; k++) s += xs[n + k] * kf[d][k];
    return fmt(d, s);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1; vx[d] = 1'b0; vf[d] = 1'b0; mr[d] = 1'b0;
    @(negedge clk);
    rst[d] = 1'b0;
    f_have[d] = 1'b0;
    chk("rst_valid", int'(yv[d]), 0);
    chk("rst_ready_x", int'(rx[d]), 1);
    chk("rst_ready_f", int'(rf[d]), 1);
    chk("rst_data", get_y(d), 0);
  endtask

  // Ready never depends on valid, so ready seen at the negedge is what the next
  // posedge samples.
  task automatic load(input int d, input int xs[$], input int fs[$], input bit rnd);
    int ix = 0, jf = 0, cyc = 0;
    if (fs.size() != 0)
      for (int k = 0; k < 4; k++) kf[d][k] = fs[k];
    while ((ix < xs.size() || jf < fs.size()) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (fs.size() == 0) chk("keepf_ready_f", int'(rf[d]), 0);
      vx[d] = (ix < xs.size()) && (!rnd || $urandom_range(0, 2) != 0);
      dx[d] = (ix < xs.size()) ? 8'(xs[ix]) : 8'd0;
      vf[d] = (jf < fs.size()) && (!rnd || $urandom_range(0, 2) != 0);
      df[d] = (jf < fs.size()) ? 8'(fs[jf]) : 8'd0;
      if (vx[d] && rx[d]) ix++;
      if (vf[d] && rf[d]) jf++;
    end
    if (cyc >= 1000) chk("load_timeout", 0, 1);
    if (fs.size() != 0) f_have[d] = 1'b1;
  endtask

  // mode 0: random ready, 1: ready held high, 2: 10-cycle stall on output 1.
  task automatic collect(input int d, input int expq[$], input int mode,
                         input bit full, output int lat);
    int got = 0, cyc = 0, last_acc = 0, hold = 0, yd;
    bit rdy, prev_hold = 0, v;
    lat = -1;
    while (got < expq.size() && cyc < 500) begin
      @(negedge clk);
      cyc++;
      vx[d] = 1'b0; vf[d] = 1'b0;
      v  = yv[d];
      yd = get_y(d);
      if (lat < 0 && v) lat = cyc - 1;
      chk("compute_ready_x", int'(rx[d]), 0);
      chk("compute_ready_f", int'(rf[d]), 0);
      if (prev_hold) begin
        chk("hold_valid", int'(v), 1);
        chk("hold_data", yd, expq[got]);
      end
      case (mode)
        0: rdy = ($urandom_range(0, 1) == 1);
        1: rdy = 1'b1;
        default: begin
          rdy = 1'b1;
          if (got == 1 && v && hold < 10) begin
            rdy = 1'b0;
            hold++;
          end
        end
      endcase
      mr[d] = rdy;
      if (v && rdy) begin
        $display("dut%0d out[%0d] = %0d (expected %0d)", d, got, yd, expq[got]);
        chk("y_value", yd, expq[got]);
        if (mode == 1 && got > 0) chk("spacing", cyc - last_acc, p_of(d));
        last_acc = cyc;
        got++;
      end
      prev_hold = v && !rdy;
    end
    if (got < expq.size()) chk("collect_timeout", got, expq.size());
    if (mode == 2) chk("bp_hold_cycles", hold, 10);
    if (full) begin
      @(negedge clk);
      chk("end_valid", int'(yv[d]), 0);
      chk("end_ready_x", int'(rx[d]), 1);
      chk("end_ready_f", int'(rf[d]), (d == 1) ? 0 : 1);
    end
  endtask

  typedef struct {
    int d; int x0; int xstep; int fv; int sendf;
    int ya; int ystep; int mode; int do_rst;
  } vec_t;

  vec_t tbl [8];

  initial begin : main
    int xs[$], fs[$], ex[$];
    int lat;
    tbl[0] = '{0,    1, 1,   1, 1,   10, 4, 1, 1};
    tbl[1] = '{0,    1, 1,   1, 1,   10, 4, 2, 0};
    tbl[2] = '{1,    1, 1,   1, 1,   10, 4, 1, 1};
    tbl[3] = '{1,    2, 2,   0, 0,   20, 8, 1, 0};
    tbl[4] = '{1,  127, 0, 127, 1,  127, 0, 0, 1};
    tbl[5] = '{1, -128, 0, 127, 1, -128, 0, 1, 1};
    tbl[6] = '{2,  127, 0, 127, 1,    4, 0, 1, 1};
    tbl[7] = '{2,    1, 1,   1, 1,   10, 4, 0, 0};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; vx[d] = 1'b0; vf[d] = 1'b0; mr[d] = 1'b0;
      dx[d] = 8'd0; df[d] = 8'd0; f_have[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) do_reset(d);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].do_rst != 0) do_reset(tbl[i].d);
      xs.delete(); fs.delete(); ex.delete();
      for (int k = 0; k < 8; k++) xs.push_back(tbl[i].x0 + k * tbl[i].xstep);
      if (tbl[i].sendf != 0)
        for (int k = 0; k < 4; k++) fs.push_back(tbl[i].fv);
      for (int k = 0; k < 5; k++) ex.push_back(tbl[i].ya + k * tbl[i].ystep);
      load(tbl[i].d, xs, fs, tbl[i].mode == 0);
      collect(tbl[i].d, ex, tbl[i].mode, 1'b1, lat);
      chk("first_latency", lat, p_of(tbl[i].d));
    end

    // Reset pulse after two outputs, then a fresh frame from n=0.
    do_reset(0);
    xs.delete(); fs.delete(); ex.delete();
    for (int k = 0; k < 8; k++) xs.push_back(k + 1);
    for (int k = 0; k < 4; k++) fs.push_back(1);
    ex.push_back(10); ex.push_back(14);
    load(0, xs, fs, 1'b0);
    collect(0, ex, 1, 1'b0, lat);
    do_reset(0);
    xs.delete(); fs.delete(); ex.delete();
    for (int k = 0; k < 8; k++) xs.push_back(3 * k - 5);
    fs.push_back(2); fs.push_back(-1); fs.push_back(0); fs.push_back(3);
    load(0, xs, fs, 1'b0);
    for (int n = 0; n < 5; n++) ex.push_back(ref_y(0, xs, n));
    collect(0, ex, 0, 1'b1, lat);

    // Randomised frames against the dot-product model.
    for (int d = 0; d < 3; d++) do_reset(d);
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 3; d++) begin
        xs.delete(); fs.delete(); ex.delete();
        for (int k = 0; k < 8; k++) xs.push_back(int'($urandom_range(0, 255)) - 128);
        if (!(d == 1 && f_have[d]))
          for (int k = 0; k < 4; k++) fs.push_back(int'($urandom_range(0, 255)) - 128);
        load(d, xs, fs, 1'b1);
        for (int n = 0; n < 5; n++) ex.push_back(ref_y(d, xs, n));
        collect(d, ex, (r == 3) ? 1 : 0, 1'b1, lat);
        chk("rand_latency", lat, p_of(d));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
